donkey_move_ctl: RTL and testbench

- Movement controller for the Donkey character. Converts debounced player controls (left, right, jump) into the sprite's top-left position.
- Sits directly upstream of the donkey sprite draw stage and feeds it xpos/ypos every clock.
- Its timing and geometry constants come from donkey_pkg.
- Horizontal walking and a vertical jump arc are each paced by a prescaled tick.

---
 rtl/donkey_pkg.sv | 28 ++
 rtl/donkey_tick_gen.sv | 30 +++
 rtl/donkey_move_ctl.sv | 142 ++++++++++++++
 tb/tb_donkey_move_ctl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/donkey_pkg.sv
// Shared constants and types for the Donkey character: screen/sprite geometry,
// movement/jump pacing and the jump FSM state encoding.
// No ports; imported by donkey_move_ctl.
package donkey_pkg;

  // Sprite geometry and screen limits.
  localparam int CHARACTER_WIDTH     = 48;
  localparam int SCREEN_WIDTH        = 1024;
  localparam int X_MAX               = SCREEN_WIDTH - CHARACTER_WIDTH;

  // Spawn / landing position of the sprite's top-left corner.
  localparam int DONKEY_INITIAL_XPOS = 128;
  localparam int DONKEY_INITIAL_YPOS = 672;

  // Jump apex height in pixels.
  localparam int DONKEY_JUMP_HEIGHT  = 61;

  // Clock cycles per 1-pixel step: vertical (jump) and horizontal (walk).
  localparam int JUMP_TAKI_W_MIARE       = 1_400_000;
  localparam int MOVE_TAKI_NIE_MACQUEEN  = 250_000;

  typedef enum logic [1:0] {
    IDLE,
    RISE,
    FALL
  } donkey_state_t;

endpackage

// File: rtl/donkey_tick_gen.sv
// Prescaler: emits a one-cycle tick every DIV enabled cycles.
// Ports: clk, rst (sync, active-high), en (level; counter clears while low),
//        tick (high on the cycle the counter sits at DIV-1 while enabled).
module donkey_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/donkey_move_ctl.sv
// Donkey movement controller: turns debounced left/right/jump levels into the
// sprite's top-left position (xpos/ypos), a jumping flag and facing direction.
// Ports: clk, rst (sync, active-high), left, right, jump in; xpos, ypos (11b),
//        jumping, facing_left out (all registered).
// Optional: define DONKEY_AIR_CONTROL_EN to allow walking while airborne.
module donkey_move_ctl
  import donkey_pkg::*;
#(
  parameter int MOVE_DIV    = MOVE_TAKI_NIE_MACQUEEN,
  parameter int JUMP_DIV    = JUMP_TAKI_W_MIARE,
  parameter int JUMP_HEIGHT = DONKEY_JUMP_HEIGHT,
  parameter int X_INIT      = DONKEY_INITIAL_XPOS,
  parameter int GROUND_Y    = DONKEY_INITIAL_YPOS,
  parameter int X_MAX       = donkey_pkg::X_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        left,
  input  logic        right,
  input  logic        jump,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        jumping,
  output logic        facing_left
);

  localparam int HW = $clog2(JUMP_HEIGHT + 1);
  localparam logic [HW-1:0] H_TOP     = HW'(JUMP_HEIGHT);
  localparam logic [10:0]   X_MAX_C   = 11'(X_MAX);
  localparam logic [10:0]   X_INIT_C  = 11'(X_INIT);
  localparam logic [10:0]   GROUND_C  = 11'(GROUND_Y);

  donkey_state_t state, state_next;
  logic [HW-1:0] height, height_next;
  logic [10:0]   ypos_next;
  logic          jump_prev;
  logic          jump_rise;
  logic          one_dir;
  logic          move_en;
  logic          move_tick;
  logic          jump_tick;

  assign one_dir   = left ^ right;
  assign jump_rise = jump & ~jump_prev;

`ifdef DONKEY_AIR_CONTROL_EN
  assign move_en = one_dir;
`else
  // Walking is frozen while airborne; the counter restarts after landing.
  assign move_en = one_dir && (state == IDLE);
`endif

  donkey_tick_gen #(.DIV(MOVE_DIV)) u_move_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (move_en),
    .tick (move_tick)
  );

  // Held at zero in IDLE, so every jump starts with a fresh full period.
  donkey_tick_gen #(.DIV(JUMP_DIV)) u_jump_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .tick (jump_tick)
  );

  // Horizontal position and facing direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos        <= X_INIT_C;
      facing_left <= 1'b0;
    end else begin
      if (move_tick) begin
        if (left && (xpos != 11'd0)) begin
          xpos <= xpos - 11'd1;
        end else if (right && (xpos != X_MAX_C)) begin
          xpos <= xpos + 11'd1;
        end
      end
      // Facing tracks the held direction immediately, not only on ticks.
      if (left && !right) begin
        facing_left <= 1'b1;
      end else if (right && !left) begin
        facing_left <= 1'b0;
      end
    end
  end

  // Jump FSM: state register plus vertical position / height registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ypos      <= GROUND_C;
      height    <= '0;
      jump_prev <= 1'b0;
      jumping   <= 1'b0;
    end else begin
      state     <= state_next;
      ypos      <= ypos_next;
      height    <= height_next;
      jump_prev <= jump;
      jumping   <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next  = state;
    ypos_next   = ypos;
    height_next = height;
    case (state)
      IDLE: begin
        if (jump_rise) begin
          state_next  = RISE;
          height_next = '0;
        end
      end
      RISE: begin
        if (jump_tick) begin
          ypos_next   = ypos - 11'd1;
          height_next = height + 1'b1;
          if (height_next == H_TOP) begin
            state_next = FALL;
          end
        end
      end
      FALL: begin
        // Edges of jump seen here (including the landing cycle) are dropped.
        if (jump_tick) begin
          ypos_next = ypos + 11'd1;
          if (ypos_next == GROUND_C) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_donkey_move_ctl.sv
// Directed bench for donkey_move_ctl with shortened pacing
// (MOVE_DIV=4, JUMP_DIV=2, JUMP_HEIGHT=5); checks walking, saturation,
// both-keys hold, jump arc, no re-trigger, air control and mid-jump reset.
module tb_donkey_move_ctl;
  import donkey_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        left;
  logic        right;
  logic        jump;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic        jumping;
  logic        facing_left;

  int checks   = 0;
  int failures = 0;

  donkey_move_ctl #(
    .MOVE_DIV    (4),
    .JUMP_DIV    (2),
    .JUMP_HEIGHT (5),
    .X_INIT      (128),
    .GROUND_Y    (672),
    .X_MAX       (976)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .left        (left),
    .right       (right),
    .jump        (jump),
    .xpos        (xpos),
    .ypos        (ypos),
    .jumping     (jumping),
    .facing_left (facing_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int  wrap_seen;
  int  cnt_nonzero;

  initial begin
    rst = 1'b1; left = 1'b0; right = 1'b0; jump = 1'b0;
    step(3);
    chk("rst_xpos", 32'(xpos), 32'd128);
    chk("rst_ypos", 32'(ypos), 32'd672);
    chk("rst_jumping", 32'(jumping), 32'd0);
    chk("rst_facing", 32'(facing_left), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;

    // Walk right: first tick on the 4th cycle, 10 ticks in 40 cycles.
    right = 1'b1;
    step(3);
    chk("right_pre_tick", 32'(xpos), 32'd128);
    step(1);
    chk("right_first_tick", 32'(xpos), 32'd129);
    step(36);
    chk("right_40_xpos", 32'(xpos), 32'd138);
    chk("right_40_facing", 32'(facing_left), 32'd0);
    chk("right_40_ypos", 32'(ypos), 32'd672);

    // Walk left into the left wall: 138 px needs 552 cycles, hold far longer.
    right = 1'b0; left = 1'b1;
    step(1);
    chk("left_facing_now", 32'(facing_left), 32'd1);
    wrap_seen = 0;
    for (int i = 0; i < 999; i++) begin
      step(1);
      if (xpos > 11'd138) wrap_seen = 1;
    end
    chk("left_sat_xpos", 32'(xpos), 32'd0);
    chk("left_no_wrap", 32'(wrap_seen), 32'd0);

    // Step right off the wall: 8 cycles -> 2 px.
    left = 1'b0; right = 1'b1;
    step(8);
    chk("off_wall_xpos", 32'(xpos), 32'd2);
    chk("off_wall_facing", 32'(facing_left), 32'd0);

    // Both keys: position and counter frozen, facing kept.
    left = 1'b1;
    cnt_nonzero = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (dut.u_move_tick.cnt != 0) cnt_nonzero = 1;
    end
    chk("both_xpos", 32'(xpos), 32'd2);
    chk("both_cnt_zero", 32'(cnt_nonzero), 32'd0);
    chk("both_facing", 32'(facing_left), 32'd0);
    left = 1'b0; right = 1'b0;
    step(2);

    // Jump, held high the whole time. Rise ticks at cycles 3,5,7,9,11;
    // fall ticks at 13,15,17,19,21.
    jump = 1'b1;
    step(1);
    chk("jump_flag_on", 32'(jumping), 32'd1);
    chk("jump_y_start", 32'(ypos), 32'd672);
    step(2);
    chk("jump_y_c3", 32'(ypos), 32'd671);
    step(8);
    chk("jump_apex", 32'(ypos), 32'd667);
    chk("jump_apex_state", 32'(dut.state), 32'(FALL));
    step(1);
    chk("jump_apex_hold", 32'(ypos), 32'd667);
    step(8);
    chk("jump_c20_y", 32'(ypos), 32'd671);
    chk("jump_c20_flag", 32'(jumping), 32'd1);
    step(1);
    chk("land_y", 32'(ypos), 32'd672);
    chk("land_flag", 32'(jumping), 32'd0);
    step(10);
    chk("held_no_retrig_flag", 32'(jumping), 32'd0);
    chk("held_no_retrig_y", 32'(ypos), 32'd672);
    jump = 1'b0;
    step(2);

    // Right held through a jump.
    jump = 1'b1; right = 1'b1;
    step(10);
`ifdef DONKEY_AIR_CONTROL_EN
    chk("air_mid_xpos", 32'(xpos), 32'd4);
`else
    chk("air_mid_xpos", 32'(xpos), 32'd2);
`endif
    step(11);
    chk("air_land_flag", 32'(jumping), 32'd0);
`ifdef DONKEY_AIR_CONTROL_EN
    chk("air_land_xpos", 32'(xpos), 32'd7);
`else
    chk("air_land_xpos", 32'(xpos), 32'd2);
`endif
    step(4);
`ifdef DONKEY_AIR_CONTROL_EN
    chk("after_land_xpos", 32'(xpos), 32'd8);
`else
    chk("after_land_xpos", 32'(xpos), 32'd3);
`endif
    jump = 1'b0; right = 1'b0;
    step(2);

    // Reset during RISE at ypos 669 (third rise tick at cycle 7).
    jump = 1'b1;
    step(7);
    chk("pre_rst_y", 32'(ypos), 32'd669);
    chk("pre_rst_state", 32'(dut.state), 32'(RISE));
    rst = 1'b1;
    step(1);
    chk("mid_rst_y", 32'(ypos), 32'd672);
    chk("mid_rst_x", 32'(xpos), 32'd128);
    chk("mid_rst_flag", 32'(jumping), 32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0; jump = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
